// File: rtl/dsp_sub_arb_pkg.sv
// rtl/dsp_sub_arb_pkg.sv - shared widths, tag type and round-robin pick for dsp_sub_arbiter
package dsp_sub_arb_pkg;

  localparam int VALUE_WIDTH = 32;
  localparam int NUM_REQ     = 4;
  localparam int ID_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int RES_W       = 2*VALUE_WIDTH + 1;
  localparam int MAX_REQ     = 32;
  localparam int MAX_IW      = $clog2(MAX_REQ);

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

  // One-hot grant: first valid requester after ptr, wrapping modulo n.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0] valid,
    input int                 ptr,
    input int                 n
  );
    logic [MAX_REQ-1:0] grant;
    logic [MAX_IW-1:0]  idx;
    grant = '0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = MAX_IW'((ptr + i) % n);
      if (i <= n && grant == '0 && valid[idx]) grant[idx] = 1'b1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/dsp_sub.sv
// rtl/dsp_sub.sv - pipelined (a-b)*c datapath; result is valid LATENCY edges after the inputs change
module dsp_sub #(
  parameter int VALUE_WIDTH = 32,
  parameter int LATENCY     = 4
) (
  input  logic                     i_clk,
  input  logic [VALUE_WIDTH-1:0]   i_presub_a,
  input  logic [VALUE_WIDTH-1:0]   i_presub_b,
  input  logic [VALUE_WIDTH-1:0]   i_mul,
  output logic [2*VALUE_WIDTH:0]   o_out
);
  localparam int RW = 2*VALUE_WIDTH + 1;

  logic signed [VALUE_WIDTH:0] presub;
  logic signed [RW-1:0]        prod;
  logic [RW-1:0]               pipe [LATENCY];

  assign presub = $signed({i_presub_a[VALUE_WIDTH-1], i_presub_a})
                - $signed({i_presub_b[VALUE_WIDTH-1], i_presub_b});
  assign prod   = RW'(presub) * RW'($signed(i_mul));

  always_ff @(posedge i_clk) begin
    pipe[0] <= prod;
    for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
  end

  assign o_out = pipe[LATENCY-1];
endmodule

// File: rtl/dsp_sub_rsp_fifo.sv
// rtl/dsp_sub_rsp_fifo.sv - synchronous response FIFO of {id, data}; wrap bit separates full from empty
module dsp_sub_rsp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_areset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, do_push, do_pop;

  assign o_empty = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = i_pop & ~o_empty;
  assign do_push = i_push & (~full | do_pop);
  // Gated so the outputs read 0 whenever nothing is queued, including in reset.
  assign o_data  = o_empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= i_push_data;
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/dsp_sub_arbiter.sv
// rtl/dsp_sub_arbiter.sv - round-robin sharing of one dsp_sub pipeline with tagged, queued responses
// Optional macro DSP_SUB_ARB_STATS_EN adds saturating issue/block counters.
module dsp_sub_arbiter
  import dsp_sub_arb_pkg::*;
#(
  parameter int VALUE_WIDTH = dsp_sub_arb_pkg::VALUE_WIDTH,
  parameter int NUM_REQ     = dsp_sub_arb_pkg::NUM_REQ,
  parameter int DSP_LATENCY = 4,
  parameter int FIFO_DEPTH  = 8,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int RES_W      = 2*VALUE_WIDTH + 1
) (
  input  logic                           i_clk,
  input  logic                           i_areset,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0] i_req_b,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0] i_req_c,
  output logic [VALUE_WIDTH-1:0]         o_dsp_a,
  output logic [VALUE_WIDTH-1:0]         o_dsp_b,
  output logic [VALUE_WIDTH-1:0]         o_dsp_c,
  input  logic [RES_W-1:0]               i_dsp_out,
  output logic                           o_rsp_valid,
  input  logic                           i_rsp_ready,
  output logic [ID_W-1:0]                o_rsp_id,
  output logic [RES_W-1:0]               o_rsp_data
`ifdef DSP_SUB_ARB_STATS_EN
  ,
  output logic [31:0]                    o_issue_cnt,
  output logic [31:0]                    o_block_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [ID_W-1:0]       ptr, win_id;
  logic [CW-1:0]         credit_used;
  logic                  credits_out, issue, pop, fifo_empty;
  logic [MAX_REQ-1:0]    pick;
  logic [NUM_REQ-1:0]    grant;
  tag_t                  issue_tag, tail_tag;
  tag_t                  tag_pipe [DSP_LATENCY];
  logic [ID_W+RES_W-1:0] fifo_data;

  assign credits_out = (credit_used == CW'(FIFO_DEPTH));
  assign pick        = rr_pick(MAX_REQ'(i_req_valid), int'(ptr), NUM_REQ);
  // Reset holds the grant low so nothing is accepted while state is cleared.
  assign grant       = (i_areset || credits_out) ? '0 : pick[NUM_REQ-1:0];
  assign o_req_ready = grant;
  assign issue       = |grant;
  assign pop         = o_rsp_valid & i_rsp_ready;
  assign tail_tag    = tag_pipe[DSP_LATENCY-1];

  always_comb begin
    win_id = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) win_id = ID_W'(i);
  end

  // issue_tag travels with o_dsp_*; the pipe behind it matches the dsp_sub latency.
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      ptr         <= ID_W'(NUM_REQ - 1);
      credit_used <= '0;
      issue_tag   <= '0;
      o_dsp_a     <= '0;
      o_dsp_b     <= '0;
      o_dsp_c     <= '0;
    end else begin
      issue_tag <= {issue, win_id};
      if (issue) begin
        ptr     <= win_id;
        o_dsp_a <= i_req_a[int'(win_id)*VALUE_WIDTH +: VALUE_WIDTH];
        o_dsp_b <= i_req_b[int'(win_id)*VALUE_WIDTH +: VALUE_WIDTH];
        o_dsp_c <= i_req_c[int'(win_id)*VALUE_WIDTH +: VALUE_WIDTH];
      end
      if (issue && !pop)      credit_used <= credit_used + CW'(1);
      else if (!issue && pop) credit_used <= credit_used - CW'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      for (int i = 0; i < DSP_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= issue_tag;
      for (int i = 1; i < DSP_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  dsp_sub_rsp_fifo #(
    .WIDTH (ID_W + RES_W),
    .DEPTH (FIFO_DEPTH)
  ) u_rsp_fifo (
    .i_clk       (i_clk),
    .i_areset    (i_areset),
    .i_push      (tail_tag.vld),
    .i_push_data ({tail_tag.id, i_dsp_out}),
    .i_pop       (pop),
    .o_data      (fifo_data),
    .o_empty     (fifo_empty)
  );

  assign o_rsp_valid = ~fifo_empty;
  assign o_rsp_id    = fifo_data[RES_W +: ID_W];
  assign o_rsp_data  = fifo_data[RES_W-1:0];

`ifdef DSP_SUB_ARB_STATS_EN
  always_ff @(posedge i_clk or posedge i_areset) begin
    if (i_areset) begin
      o_issue_cnt <= '0;
      o_block_cnt <= '0;
    end else begin
      if (issue && o_issue_cnt != '1) o_issue_cnt <= o_issue_cnt + 32'd1;
      if (|i_req_valid && credits_out && o_block_cnt != '1) o_block_cnt <= o_block_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dsp_sub_arbiter.sv
// tb/tb_dsp_sub_arbiter.sv - directed self-checking bench for dsp_sub_arbiter with a real dsp_sub
module tb_dsp_sub_arbiter;
  localparam int W  = 32;
  localparam int N  = 4;
  localparam int RW = 2*W + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b, req_c;
  logic [W-1:0]   dsp_a, dsp_b, dsp_c;
  logic [RW-1:0]  dsp_out, rsp_data;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
`ifdef DSP_SUB_ARB_STATS_EN
  logic [31:0]    issue_cnt, block_cnt;
`endif

  int            n_cmp = 0;
  int            n_bad = 0;
  int            nxt, acc, stalled;
  logic          hs;
  logic [RW-1:0] held;
  logic [RW-1:0] data_q [$];
  int            id_q [$];

  always #5 clk = ~clk;

  dsp_sub_arbiter u_dut (
    .i_clk       (clk),
    .i_areset    (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_c     (req_c),
    .o_dsp_a     (dsp_a),
    .o_dsp_b     (dsp_b),
    .o_dsp_c     (dsp_c),
    .i_dsp_out   (dsp_out),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_data  (rsp_data)
`ifdef DSP_SUB_ARB_STATS_EN
    ,
    .o_issue_cnt (issue_cnt),
    .o_block_cnt (block_cnt)
`endif
  );

  dsp_sub #(.VALUE_WIDTH(W), .LATENCY(4)) u_dsp (
    .i_clk      (clk),
    .i_presub_a (dsp_a),
    .i_presub_b (dsp_b),
    .i_mul      (dsp_c),
    .o_out      (dsp_out)
  );

  always @(negedge clk) begin
    if (rst !== 1'b1 && rsp_valid && rsp_ready) begin
      data_q.push_back(rsp_data);
      id_q.push_back(int'(rsp_id));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input int a, input int b, input int c);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
    req_c[i*W +: W] = W'(c);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    data_q.delete();
    id_q.delete();
  endtask

  task automatic drain(input int want, input int budget);
    for (int t = 0; t < budget && data_q.size() < want; t++) step();
  endtask

  // req0 streams a=nxt,b=0,c=1 so each result equals its a operand.
  task automatic stream(input int cycles);
    for (int t = 0; t < cycles; t++) begin
      #1;
      hs = (req_ready[0] === 1'b1);
      if (!hs) stalled++;
      @(posedge clk);
      #1;
      if (hs) begin
        acc++;
        nxt++;
        set_op(0, nxt, 0, 1);
      end
    end
  endtask

  task automatic test_reset();
    req_valid = '1;
    step();
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    n_cmp++; if ({dsp_a, dsp_b, dsp_c} !== '0) begin n_bad++; $display("FAIL reset_dsp: got %h %h %h want 0", dsp_a, dsp_b, dsp_c); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_cmp++; if (rsp_id !== 2'd0 || rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp: got id %0d data %h want 0", rsp_id, rsp_data); end
  endtask

  task automatic test_single();
    int lat;
    logic [RW-1:0] e;
    reset_dut();
    set_op(0, 3, 4, 5);
    req_valid = 4'b0001;
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    n_cmp++; if (dsp_a !== 32'd3 || dsp_b !== 32'd4 || dsp_c !== 32'd5) begin n_bad++; $display("FAIL single_dsp_regs: got %0d %0d %0d want 3 4 5", dsp_a, dsp_b, dsp_c); end
    lat = 0;
    e = RW'(-5);
    for (int j = 1; j <= 8 && lat == 0; j++) begin
      step();
      if (rsp_valid === 1'b1) begin
        lat = j;
        n_cmp++; if (rsp_id !== 2'd0 || rsp_data !== e) begin n_bad++; $display("FAIL single_rsp: got id %0d data %h want id 0 data %h", rsp_id, rsp_data, e); end
      end
    end
    n_cmp++; if (lat != 5) begin n_bad++; $display("FAIL single_latency: got %0d want 5", lat); end
    step();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_popped: got %b want 0", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [N-1:0] exp_g;
    reset_dut();
    for (int i = 0; i < N; i++) set_op(i, 5, 4, i + 1);
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_g = N'(1 << (k % N));
      n_cmp++; if (req_ready !== exp_g) begin n_bad++; $display("FAIL contention_grant%0d: got %b want %b", k, req_ready, exp_g); end
      step();
    end
    req_valid = '0;
    drain(8, 30);
    n_cmp++; if (data_q.size() != 8) begin n_bad++; $display("FAIL contention_count: got %0d want 8", data_q.size()); end
    for (int k = 0; k < data_q.size() && k < 8; k++) begin
      n_cmp++; if (id_q[k] != k % N || data_q[k] !== RW'(k % N + 1)) begin n_bad++; $display("FAIL contention_rsp%0d: got id %0d data %0d want id %0d data %0d", k, id_q[k], data_q[k], k % N, k % N + 1); end
    end
  endtask

  task automatic test_fairness();
    reset_dut();
    for (int i = 0; i < N; i++) set_op(i, 1, 0, i);
    req_valid = 4'b1010;
    #1; n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL fair_g0: got %b want 0010", req_ready); end
    step();
    n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL fair_g1: got %b want 1000", req_ready); end
    step();
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL fair_g2: got %b want 0010", req_ready); end
    step();
    req_valid = '0;
    #1; n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL fair_idle: got %b want 0000", req_ready); end
    step();
    step();
    req_valid = 4'b1010;
    #1; n_cmp++; if (req_ready !== 4'b1000) begin n_bad++; $display("FAIL fair_after_idle: got %b want 1000", req_ready); end
    step();
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL fair_g4: got %b want 0010", req_ready); end
    step();
    req_valid = '0;
    drain(5, 20);
    n_cmp++; if (data_q.size() != 5) begin n_bad++; $display("FAIL fair_count: got %0d want 5", data_q.size()); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    rsp_ready = 1'b0;
    nxt = 10; acc = 0; stalled = 0;
    for (int i = 0; i < N; i++) set_op(i, 0, 0, 1);
    set_op(0, nxt, 0, 1);
    req_valid = 4'b0001;
    stream(20);
    n_cmp++; if (acc != 8) begin n_bad++; $display("FAIL bp_accepted: got %0d want 8", acc); end
    n_cmp++; if (stalled != 12) begin n_bad++; $display("FAIL bp_stalled: got %0d want 12", stalled); end
`ifdef DSP_SUB_ARB_STATS_EN
    n_cmp++; if (issue_cnt !== 32'd8) begin n_bad++; $display("FAIL stats_issue: got %0d want 8", issue_cnt); end
    n_cmp++; if (block_cnt !== 32'd12) begin n_bad++; $display("FAIL stats_block: got %0d want 12", block_cnt); end
`endif
    req_valid = '0;
    held = rsp_data;
    n_cmp++; if (rsp_valid !== 1'b1 || held !== RW'(10)) begin n_bad++; $display("FAIL bp_head: got v%b data %0d want v1 data 10", rsp_valid, held); end
    step();
    step();
    n_cmp++; if (rsp_data !== RW'(10)) begin n_bad++; $display("FAIL bp_stable: got %0d want 10", rsp_data); end
    rsp_ready = 1'b1;
    drain(8, 30);
    step();
    step();
    n_cmp++; if (data_q.size() != 8) begin n_bad++; $display("FAIL bp_count: got %0d want 8", data_q.size()); end
    for (int k = 0; k < data_q.size() && k < 8; k++) begin
      n_cmp++; if (data_q[k] !== RW'(10 + k)) begin n_bad++; $display("FAIL bp_data%0d: got %0d want %0d", k, data_q[k], 10 + k); end
    end
    req_valid = 4'b0001;
    #1; n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL bp_resume: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
  endtask

  task automatic test_midflight_reset();
    reset_dut();
    for (int i = 0; i < N; i++) set_op(i, 5, 4, i + 1);
    req_valid = 4'b0111;
    step();
    step();
    step();
    req_valid = 4'b1111;
    rst = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL mrst_ready: got %b want 0000", req_ready); end
    n_cmp++; if ({dsp_a, dsp_b, dsp_c} !== '0) begin n_bad++; $display("FAIL mrst_dsp: got %h %h %h want 0", dsp_a, dsp_b, dsp_c); end
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== 2'd0) begin n_bad++; $display("FAIL mrst_rsp: got v%b id %0d data %h want 0", rsp_valid, rsp_id, rsp_data); end
    step();
    step();
    rst = 1'b0;
    data_q.delete();
    id_q.delete();
    #1;
    n_cmp++; if (req_ready !== 4'b0001) begin n_bad++; $display("FAIL mrst_first_grant: got %b want 0001", req_ready); end
    step();
    req_valid = '0;
    for (int t = 0; t < 12; t++) step();
    n_cmp++; if (data_q.size() != 1) begin n_bad++; $display("FAIL mrst_stale: got %0d responses want 1", data_q.size()); end
    else begin
      n_cmp++; if (id_q[0] != 0 || data_q[0] !== RW'(1)) begin n_bad++; $display("FAIL mrst_rsp_value: got id %0d data %0d want id 0 data 1", id_q[0], data_q[0]); end
    end
  endtask

  task automatic test_full_pushpop();
    reset_dut();
    rsp_ready = 1'b0;
    nxt = 100; acc = 0; stalled = 0;
    set_op(0, nxt, 0, 1);
    req_valid = 4'b0001;
    stream(16);
    n_cmp++; if (acc != 8) begin n_bad++; $display("FAIL full_fill: got %0d want 8", acc); end
    rsp_ready = 1'b1;
    stream(24);
    rsp_ready = 1'b0;
    stream(12);
    n_cmp++; if (acc - data_q.size() != 8) begin n_bad++; $display("FAIL full_credits: got %0d outstanding want 8", acc - data_q.size()); end
    req_valid = '0;
    rsp_ready = 1'b1;
    drain(acc, 60);
    step();
    step();
    n_cmp++; if (data_q.size() != acc) begin n_bad++; $display("FAIL full_count: got %0d want %0d", data_q.size(), acc); end
    for (int k = 0; k < data_q.size(); k++) begin
      n_cmp++; if (data_q[k] !== RW'(100 + k) || id_q[k] != 0) begin n_bad++; $display("FAIL full_seq%0d: got id %0d data %0d want id 0 data %0d", k, id_q[k], data_q[k], 100 + k); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    req_a = '0;
    req_b = '0;
    req_c = '0;
    #2 rst = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_backpressure();
    test_midflight_reset();
    test_full_pushpop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
